// File: rtl/pwm_capture_if.sv
// Result/handshake bundle of pwm_capture: captured values flow master -> slave,
// cap_ack flows back from the consumer.
interface pwm_capture_if #(
    parameter int WIDTH = 16
) ();
    logic [WIDTH-1:0] period_val;
    logic [WIDTH-1:0] high_val;
    logic             cap_valid;
    logic             cap_ovf;
    logic             cap_missed;
    logic             cap_ack;

    modport master (
        output period_val,
        output high_val,
        output cap_valid,
        output cap_ovf,
        output cap_missed,
        input  cap_ack
    );

    modport slave (
        input  period_val,
        input  high_val,
        input  cap_valid,
        input  cap_ovf,
        input  cap_missed,
        output cap_ack
    );
endinterface

// File: rtl/pwm_capture.sv
// pwm_capture: timestamps sig_in edges in prescaled ticks and reports period and high time.
// Define PWM_CAP_HIGH_EN to include high-time measurement; without it only the period is captured.
module pwm_capture #(
    parameter int WIDTH = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic          soft_reset,
    input  logic [7:0]    prescale,
    input  logic          sig_in,
    pwm_capture_if.master cap
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    // State entered after a rising edge starts a new measurement window.
`ifdef PWM_CAP_HIGH_EN
    localparam state_t ARM_STATE = HIGH;
`else
    localparam state_t ARM_STATE = LOW;
`endif

    state_t           state_q, state_d;
    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             s3_q, s3_d;
    logic [7:0]       pre_cnt_q, pre_cnt_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             ovf_q, ovf_d;
    logic             valid_q, valid_d;
    logic             missed_q, missed_d;
`ifdef PWM_CAP_HIGH_EN
    logic [WIDTH-1:0] hi_cnt_q, hi_cnt_d;
    logic [WIDTH-1:0] high_q, high_d;
    logic             fall;
`endif

    logic             rise;
    logic             tick;
    logic [WIDTH:0]   sum;
    logic             inc_ovf;
    logic [WIDTH-1:0] inc;
    logic             capture;

    assign rise = s2_q & ~s3_q;
`ifdef PWM_CAP_HIGH_EN
    assign fall = ~s2_q & s3_q;
`endif
    assign tick    = enable & (pre_cnt_q == prescale);
    assign sum     = {1'b0, cnt_q} + (WIDTH+1)'(tick);
    assign inc_ovf = sum[WIDTH];
    assign inc     = inc_ovf ? {WIDTH{1'b1}} : sum[WIDTH-1:0];

    // The synchronizer ignores enable and soft_reset so edge history survives a clear.
    always_comb begin
        s1_d = sig_in;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    always_comb begin
        state_d   = state_q;
        pre_cnt_d = pre_cnt_q;
        cnt_d     = cnt_q;
        sat_d     = sat_q;
        period_d  = period_q;
        ovf_d     = ovf_q;
        valid_d   = valid_q;
        missed_d  = missed_q;
`ifdef PWM_CAP_HIGH_EN
        hi_cnt_d  = hi_cnt_q;
        high_d    = high_q;
`endif
        capture   = 1'b0;

        if (soft_reset) begin
            state_d   = IDLE;
            pre_cnt_d = '0;
            cnt_d     = '0;
            sat_d     = 1'b0;
            period_d  = '0;
            ovf_d     = 1'b0;
            valid_d   = 1'b0;
            missed_d  = 1'b0;
`ifdef PWM_CAP_HIGH_EN
            hi_cnt_d  = '0;
            high_d    = '0;
`endif
        end else begin
            if (!enable) begin
                state_d   = IDLE;
                pre_cnt_d = '0;
                cnt_d     = '0;
                sat_d     = 1'b0;
            end else begin
                pre_cnt_d = tick ? 8'd0 : pre_cnt_q + 8'd1;
                case (state_q)
                    IDLE: begin
                        if (rise) begin
                            cnt_d   = '0;
                            sat_d   = 1'b0;
                            state_d = ARM_STATE;
                        end
                    end
`ifdef PWM_CAP_HIGH_EN
                    HIGH: begin
                        cnt_d = inc;
                        sat_d = sat_q | inc_ovf;
                        // A rise here cannot follow a clean sync; handle it like LOW.
                        if (rise) begin
                            capture = 1'b1;
                        end else if (fall) begin
                            hi_cnt_d = inc;
                            state_d  = LOW;
                        end
                    end
`endif
                    LOW: begin
                        cnt_d = inc;
                        sat_d = sat_q | inc_ovf;
                        if (rise) begin
                            capture = 1'b1;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end

            // A capture coinciding with an ack wins: the fresh result stays pending.
            if (capture) begin
                period_d = inc;
                ovf_d    = sat_q | inc_ovf;
                valid_d  = 1'b1;
                if (valid_q && !cap.cap_ack) begin
                    missed_d = 1'b1;
                end
`ifdef PWM_CAP_HIGH_EN
                high_d   = hi_cnt_q;
`endif
                cnt_d    = '0;
                sat_d    = 1'b0;
                state_d  = ARM_STATE;
            end else if (cap.cap_ack) begin
                valid_d  = 1'b0;
                missed_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pre_cnt_q <= '0;
            cnt_q     <= '0;
            sat_q     <= 1'b0;
            period_q  <= '0;
            ovf_q     <= 1'b0;
            valid_q   <= 1'b0;
            missed_q  <= 1'b0;
`ifdef PWM_CAP_HIGH_EN
            hi_cnt_q  <= '0;
            high_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            pre_cnt_q <= pre_cnt_d;
            cnt_q     <= cnt_d;
            sat_q     <= sat_d;
            period_q  <= period_d;
            ovf_q     <= ovf_d;
            valid_q   <= valid_d;
            missed_q  <= missed_d;
`ifdef PWM_CAP_HIGH_EN
            hi_cnt_q  <= hi_cnt_d;
            high_q    <= high_d;
`endif
        end
    end

    assign cap.period_val = period_q;
    assign cap.cap_valid  = valid_q;
    assign cap.cap_ovf    = ovf_q;
    assign cap.cap_missed = missed_q;
`ifdef PWM_CAP_HIGH_EN
    assign cap.high_val   = high_q;
`else
    assign cap.high_val   = '0;
`endif

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Input-capture unit: the measuring counterpart of the prescaled timer `counter`. It timestamps edges of an external pulse train using the same prescaler semantics. It reports the period (rising edge to rising edge) and the high time (rising edge to falling edge) in prescaled ticks. A valid/ack handshake lets the register interface collect each result.

## Interface
- `WIDTH`, default 16: width of the tick counter and of the captured results.
- `clk`  input  1  system clock.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `enable`  input  1  capture enable.
- `soft_reset`  input  1  synchronous clear, same effect as reset.
- `prescale`  input  8  tick every `prescale+1` enabled cycles.
- `sig_in`  input  1  asynchronous measured signal.
- `cap_ack`  input  1  consumer has read the current result.
- `period_val`  output  WIDTH  last captured period in ticks.
- `high_val`  output  WIDTH  last captured high time in ticks.
- `cap_valid`  output  1  result pending.
- `cap_ovf`  output  1  the last result saturated.
- `cap_missed`  output  1  a result was overwritten before it was acked.

## Operation
- **Synchronizer:**
  - `sig_in` passes through two flops, `s1` then `s2`, and `s2` is delayed one more cycle into `s3`.
  - `rise = s2 & ~s3`, `fall = ~s2 & s3`.
  - The synchronizer runs regardless of `enable` and `soft_reset`.
- **Prescaler:**
  - `pre_cnt` is 8-bit, and `tick = enable & (pre_cnt == prescale)`.
  - On a tick, `pre_cnt` is set to 0; otherwise, while enabled, it increments.
  - The prescaler is free-running. It is not realigned to edges.
- **Tick counter `cnt`:**
  - Width is WIDTH. `inc = cnt + tick`, saturating at `2^WIDTH-1`.
  - A sticky `sat` bit is set when the increment would exceed the maximum value.
- **FSM states:** IDLE, HIGH, LOW.
  - IDLE: on `rise`, set `cnt`←0 and `sat`←0, then go to HIGH. No capture is made.
  - HIGH: `cnt`←`inc`. On `fall`, latch `hi_cnt`←`inc` and go to LOW.
  - LOW: `cnt`←`inc`. On `rise`, perform a capture, then set `cnt`←0 and `sat`←0 and go to HIGH.
  - HIGH with `rise`: this is impossible after synchronization. If it occurs, treat it as in LOW.
- **Capture:** `period_val`←`inc`, `high_val`←`hi_cnt`, `cap_ovf`←`sat` or overflow in this cycle, `cap_valid`←1.
- **Handshake:**
  - `cap_valid` holds until a cycle with `cap_ack`=1, which clears `cap_valid` and `cap_missed`.
  - A capture while `cap_valid`=1 and `cap_ack`=0 overwrites the results and sets `cap_missed`.
  - A capture in the same cycle as `cap_ack`: the capture wins, `cap_valid` stays 1, `cap_missed` is unchanged.
- **`enable`=0:**
  - FSM is forced to IDLE; `cnt`, `pre_cnt` and `sat` are cleared.
  - Outputs and handshake hold. `cap_ack` is still honoured.
  - Edges are ignored.
- **Reset:** `rst_n` low or `soft_reset` high clears every register to 0 and puts the FSM in IDLE. `soft_reset` takes priority over `enable` and `cap_ack`.

## Timing
- Reset values: `period_val`=0, `high_val`=0, `cap_valid`=0, `cap_ovf`=0, `cap_missed`=0.
- Latency: a `sig_in` rising edge sampled at clock k produces `rise` in cycle k+2. Results and `cap_valid` are visible after clock k+2, i.e. 3 clocks after sampling.
- Accuracy:
  - With `prescale`=0, results are exact in clock cycles. A period of P cycles reports P; a high time of H cycles reports H.
  - With `prescale`=N>0, results are `floor` or `ceil` of cycles/(N+1), depending on prescaler phase.
- The first capture after reset, enable or IDLE needs two rising edges.
- Minimum measurable high or low phase is 2 cycles. Shorter pulses may be lost in the synchronizer.
- A `prescale` change takes effect at the next compare. If `pre_cnt` > new `prescale`, it wraps through 255.

## Configuration
- `PWM_CAP_HIGH_EN`:
  - When defined: high-time measurement as described above.
  - When undefined:
    - `hi_cnt` logic is removed and `high_val` is tied to 0.
    - `fall` is ignored, and the FSM uses only IDLE and LOW. IDLE goes to LOW on `rise`.
    - Period capture is unchanged.

## Test plan
- `prescale`=0; `sig_in` with period 10 and high 3, acking each result → `period_val`=10, `high_val`=3, `cap_ovf`=0, `cap_missed`=0 on every capture after the first.
- `prescale`=3; period 40, high 20 → `period_val` ∈ {10}, `high_val` ∈ {5}, ±1 across phases.
- WIDTH=8, `prescale`=0, period 300 → `period_val`=255, `cap_ovf`=1. The next normal period of 10 → `cap_ovf`=0.
- No ack across two captures with periods 10 then 12 → `period_val`=12, `cap_missed`=1. `cap_ack` clears both flags. Capture coincident with ack → `cap_valid` stays 1.
- `soft_reset` asserted in LOW → all outputs 0, FSM in IDLE. The next rising edge gives no capture; the following one captures.
- `rst_n` pulsed low asynchronously mid-HIGH → outputs 0 immediately. `enable`=0 in the middle of a period → no capture until two rises after re-enable.
